// File: rtl/mem_access_seq_if.sv
// -----------------------------------------------------------------------------
// mem_access_seq_if
//
// Bundles the host-side strobes/buses and the SRAM pins of mem_access_seq.
//
// Host side:
//   addr_in/addr_en    address bus value and its "driven" qualifier
//   xfer_in            transfer bus value (write data)
//   rd_n/wr_n          active-low read/write start strobes
//   post_inc_n         active-low post-increment request
//   assert_xfer        active-low drive enable for the memory data register
//   xfer_out/xfer_en   memory data register and its bus drive enable
//   inc_n              active-low increment pulse to the address register
//   busy/done/err      sequencer status
// SRAM side:
//   mem_addr/mem_wdata/mem_rdata, mem_ce_n/mem_oe_n/mem_we_n
//
// Modports: slave = sequencer, master = whoever drives the host side and
// models the SRAM.
// -----------------------------------------------------------------------------
interface mem_access_seq_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);

  logic [ADDR_WIDTH-1:0] addr_in;
  logic                  addr_en;
  logic [DATA_WIDTH-1:0] xfer_in;
  logic                  rd_n;
  logic                  wr_n;
  logic                  post_inc_n;
  logic                  assert_xfer;
  logic [DATA_WIDTH-1:0] xfer_out;
  logic                  xfer_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ce_n;
  logic                  mem_oe_n;
  logic                  mem_we_n;
  logic                  inc_n;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport slave (
    input  addr_in, addr_en, xfer_in, rd_n, wr_n, post_inc_n, assert_xfer,
           mem_rdata,
    output xfer_out, xfer_en, mem_addr, mem_wdata, mem_ce_n, mem_oe_n,
           mem_we_n, inc_n, busy, done, err
  );

  modport master (
    output addr_in, addr_en, xfer_in, rd_n, wr_n, post_inc_n, assert_xfer,
           mem_rdata,
    input  xfer_out, xfer_en, mem_addr, mem_wdata, mem_ce_n, mem_oe_n,
           mem_we_n, inc_n, busy, done, err
  );

endinterface

// File: rtl/mem_access_seq.sv
// -----------------------------------------------------------------------------
// mem_access_seq
//
// Multi-cycle SRAM access sequencer. In IDLE it samples the address bus and
// the transfer bus when exactly one of rd_n/wr_n is low and the address bus is
// driven, then runs SETUP -> ACCESS (WAIT_STATES+1 cycles) -> FINISH. Read data
// is captured into the memory data register on the last ACCESS edge and is
// permanently presented on xfer_out. Malformed requests in IDLE produce a
// one-cycle err pulse; strobes outside IDLE are ignored.
//
// Parameters:
//   ADDR_WIDTH   address bus / SRAM address width
//   DATA_WIDTH   transfer bus / SRAM data width
//   WAIT_STATES  extra ACCESS cycles, 0..15
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high reset, priority over any request
//   bus    mem_access_seq_if.slave (host strobes, transfer bus, SRAM pins)
//
// All outputs are registered except xfer_out (data register) and xfer_en.
// -----------------------------------------------------------------------------
module mem_access_seq #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  mem_access_seq_if.slave   bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  // Wait counter is 4 bits wide, so only the low nibble of WAIT_STATES matters.
  localparam logic [3:0] WAIT_LD = 4'(WAIT_STATES);

  logic [1:0]            r_state;
  logic [3:0]            r_cnt;
  logic                  r_op_rd;     // latched op: 1 = read, 0 = write
  logic                  r_post_inc;  // latched post-increment request
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [DATA_WIDTH-1:0] r_data;      // memory data register
  logic                  r_ce_n;
  logic                  r_oe_n;
  logic                  r_we_n;
  logic                  r_inc_n;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_any_req;
  logic                  w_is_read;

  // A request is well formed only with exactly one strobe low and the
  // address bus actually driven; anything else with a strobe low is rejected.
  assign w_accept  = (bus.rd_n ^ bus.wr_n) & bus.addr_en;
  assign w_any_req = ~bus.rd_n | ~bus.wr_n;
  assign w_is_read = ~bus.rd_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_op_rd     <= 1'b0;
      r_post_inc  <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_data      <= '0;
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_inc_n     <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // Pulse outputs default to inactive and are raised for one cycle below.
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_inc_n <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state    <= ST_SETUP;
            r_busy     <= 1'b1;
            r_ce_n     <= 1'b0;
            r_mem_addr <= bus.addr_in;
            r_op_rd    <= w_is_read;
            r_post_inc <= ~bus.post_inc_n;
            if (!w_is_read) begin
              r_mem_wdata <= bus.xfer_in;
            end
          end else if (w_any_req) begin
            r_err <= 1'b1;
          end
        end

        // Address has settled for one cycle with only chip enable low, so
        // the direction strobe never moves together with the address.
        ST_SETUP: begin
          r_state <= ST_ACCESS;
          r_cnt   <= WAIT_LD;
          r_oe_n  <= ~r_op_rd;
          r_we_n  <= r_op_rd;
        end

        // Counter runs WAIT_LD..0, giving WAIT_STATES+1 ACCESS cycles.
        ST_ACCESS: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_FINISH;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_done  <= 1'b1;
            r_inc_n <= ~r_post_inc;
            if (r_op_rd) begin
              r_data <= bus.mem_rdata;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        ST_FINISH: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_ce_n  <= 1'b1;
          r_oe_n  <= 1'b1;
          r_we_n  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.xfer_out  = r_data;
  assign bus.xfer_en   = ~bus.assert_xfer;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_ce_n  = r_ce_n;
  assign bus.mem_oe_n  = r_oe_n;
  assign bus.mem_we_n  = r_we_n;
  assign bus.inc_n     = r_inc_n;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_mem_access_seq.sv
// -----------------------------------------------------------------------------
// tb_mem_access_seq
//
// Directed bench for mem_access_seq. Three instances cover WAIT_STATES 0, 1
// and 3. Inputs change and outputs are sampled on the falling edge; cycle k of
// a transaction is the k-th falling edge after the request edge.
// -----------------------------------------------------------------------------
module tb_mem_access_seq;

  logic clk;
  logic rst0, rst1, rst3;
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_access_seq_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) if0 ();
  mem_access_seq_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) if1 ();
  mem_access_seq_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) if3 ();

  mem_access_seq #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .WAIT_STATES(0))
    u_w0 (.clk(clk), .reset(rst0), .bus(if0));
  mem_access_seq #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .WAIT_STATES(1))
    u_w1 (.clk(clk), .reset(rst1), .bus(if1));
  mem_access_seq #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .WAIT_STATES(3))
    u_w3 (.clk(clk), .reset(rst3), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    if0.addr_in = '0; if0.addr_en = 0; if0.xfer_in = '0; if0.rd_n = 1; if0.wr_n = 1;
    if0.post_inc_n = 1; if0.assert_xfer = 1; if0.mem_rdata = '0;
    if1.addr_in = '0; if1.addr_en = 0; if1.xfer_in = '0; if1.rd_n = 1; if1.wr_n = 1;
    if1.post_inc_n = 1; if1.assert_xfer = 1; if1.mem_rdata = '0;
    if3.addr_in = '0; if3.addr_en = 0; if3.xfer_in = '0; if3.rd_n = 1; if3.wr_n = 1;
    if3.post_inc_n = 1; if3.assert_xfer = 1; if3.mem_rdata = '0;
  endtask

  task automatic test_reset();
    logic [2:0] strobes;
    strobes = {if1.mem_ce_n, if1.mem_oe_n, if1.mem_we_n};
    n_checks++; if (strobes !== 3'b111) begin n_fail++; $display("FAIL reset_strobes: got %b want 111", strobes); end
    n_checks++; if (if1.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", if1.busy); end
    n_checks++; if ({if1.done, if1.err} !== 2'b00) begin n_fail++; $display("FAIL reset_done_err: got %b want 00", {if1.done, if1.err}); end
    n_checks++; if (if1.inc_n !== 1'b1) begin n_fail++; $display("FAIL reset_inc_n: got %b want 1", if1.inc_n); end
    n_checks++; if (if1.xfer_out !== 8'h00) begin n_fail++; $display("FAIL reset_xfer_out: got %h want 00", if1.xfer_out); end
    n_checks++; if (if1.mem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0000", if1.mem_addr); end
    n_checks++; if (if1.mem_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_mem_wdata: got %h want 00", if1.mem_wdata); end
    n_checks++; if (if1.xfer_en !== 1'b0) begin n_fail++; $display("FAIL reset_xfer_en: got %b want 0", if1.xfer_en); end
    n_checks++; if ({if0.busy, if3.busy, if0.mem_ce_n, if3.mem_ce_n} !== 4'b0011) begin n_fail++; $display("FAIL reset_other_inst: got %b want 0011", {if0.busy, if3.busy, if0.mem_ce_n, if3.mem_ce_n}); end
  endtask

  task automatic test_read();
    int oe_cnt = 0, done_cnt = 0, done_at = -1, inc_low = 0;
    if1.addr_in = 16'h1234; if1.addr_en = 1; if1.rd_n = 0; if1.mem_rdata = 8'hA5;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_checks++; if ({if1.busy, if1.mem_ce_n, if1.mem_oe_n, if1.mem_we_n} !== 4'b1011) begin n_fail++; $display("FAIL read_setup_strobes: got %b want 1011", {if1.busy, if1.mem_ce_n, if1.mem_oe_n, if1.mem_we_n}); end
        n_checks++; if (if1.mem_addr !== 16'h1234) begin n_fail++; $display("FAIL read_addr: got %h want 1234", if1.mem_addr); end
        if1.rd_n = 1; if1.addr_en = 0; if1.addr_in = '0;
      end
      if (if1.mem_oe_n == 1'b0) oe_cnt++;
      if (if1.done == 1'b1) begin done_cnt++; done_at = k; end
      if (if1.inc_n == 1'b0) inc_low++;
      if (k == 4) begin
        n_checks++; if (if1.xfer_out !== 8'hA5) begin n_fail++; $display("FAIL read_data_at_done: got %h want a5", if1.xfer_out); end
        if1.mem_rdata = 8'h00;
      end
    end
    n_checks++; if (oe_cnt != 2) begin n_fail++; $display("FAIL read_oe_cycles: got %0d want 2", oe_cnt); end
    n_checks++; if (done_cnt != 1 || done_at != 4) begin n_fail++; $display("FAIL read_done: got count %0d at %0d want 1 at 4", done_cnt, done_at); end
    n_checks++; if (inc_low != 0) begin n_fail++; $display("FAIL read_inc_n: got %0d low cycles want 0", inc_low); end
    n_checks++; if (if1.busy !== 1'b0) begin n_fail++; $display("FAIL read_busy_end: got %b want 0", if1.busy); end
    n_checks++; if (if1.xfer_out !== 8'hA5) begin n_fail++; $display("FAIL read_data_held: got %h want a5", if1.xfer_out); end
    if1.assert_xfer = 0;
    #1;
    n_checks++; if (if1.xfer_en !== 1'b1) begin n_fail++; $display("FAIL read_xfer_en: got %b want 1", if1.xfer_en); end
    if1.assert_xfer = 1;
  endtask

  task automatic test_write();
    int we_cnt = 0, oe_cnt = 0, done_at = -1, inc_at = -1, inc_cnt = 0, addr_bad = 0;
    if0.addr_in = 16'hFFFF; if0.xfer_in = 8'h3C; if0.wr_n = 0; if0.addr_en = 1; if0.post_inc_n = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if0.wr_n = 1; if0.addr_en = 0; if0.post_inc_n = 1; if0.xfer_in = '0; if0.addr_in = '0;
      end
      if (if0.mem_we_n == 1'b0) we_cnt++;
      if (if0.mem_oe_n == 1'b0) oe_cnt++;
      if (if0.done == 1'b1) done_at = k;
      if (if0.inc_n == 1'b0) begin inc_at = k; inc_cnt++; end
      if (k <= 3 && if0.mem_addr !== 16'hFFFF) addr_bad++;
    end
    n_checks++; if (we_cnt != 1 || oe_cnt != 0) begin n_fail++; $display("FAIL write_strobes: got we %0d oe %0d want we 1 oe 0", we_cnt, oe_cnt); end
    n_checks++; if (done_at != 3 || inc_at != 3 || inc_cnt != 1) begin n_fail++; $display("FAIL write_done_inc: got done@%0d inc@%0d x%0d want 3 3 x1", done_at, inc_at, inc_cnt); end
    n_checks++; if (addr_bad != 0) begin n_fail++; $display("FAIL write_addr_stable: got %0d bad cycles want 0", addr_bad); end
    n_checks++; if (if0.mem_wdata !== 8'h3C || if0.mem_addr !== 16'hFFFF) begin n_fail++; $display("FAIL write_latched: got %h/%h want 3c/ffff", if0.mem_wdata, if0.mem_addr); end
    n_checks++; if (if0.xfer_out !== 8'h00) begin n_fail++; $display("FAIL write_xfer_out: got %h want 00", if0.xfer_out); end
  endtask

  task automatic test_reject();
    int err_cnt = 0, done_cnt = 0;
    if1.rd_n = 0; if1.wr_n = 0; if1.addr_en = 1; if1.addr_in = 16'h5555;
    @(negedge clk);
    n_checks++; if ({if1.err, if1.busy, if1.mem_ce_n} !== 3'b101) begin n_fail++; $display("FAIL reject_both: got err/busy/ce %b want 101", {if1.err, if1.busy, if1.mem_ce_n}); end
    if1.rd_n = 1; if1.wr_n = 1;
    @(negedge clk);
    n_checks++; if (if1.err !== 1'b0) begin n_fail++; $display("FAIL reject_err_pulse: got %b want 0", if1.err); end
    if1.rd_n = 0; if1.addr_en = 0;
    @(negedge clk);
    n_checks++; if ({if1.err, if1.busy, if1.mem_ce_n} !== 3'b101) begin n_fail++; $display("FAIL reject_no_addr: got err/busy/ce %b want 101", {if1.err, if1.busy, if1.mem_ce_n}); end
    n_checks++; if (if1.mem_addr !== 16'h1234) begin n_fail++; $display("FAIL reject_addr_kept: got %h want 1234", if1.mem_addr); end
    if1.rd_n = 1;
    @(negedge clk);
    if1.addr_in = 16'h0042; if1.addr_en = 1; if1.rd_n = 0; if1.mem_rdata = 8'h11;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (if1.err == 1'b1) err_cnt++;
      if (if1.done == 1'b1) done_cnt++;
      if (k == 4) begin if1.rd_n = 1; if1.addr_en = 0; end
      if (k == 5) begin
        n_checks++; if ({if1.busy, if1.mem_ce_n} !== 2'b01) begin n_fail++; $display("FAIL held_rd_no_requeue: got busy/ce %b want 01", {if1.busy, if1.mem_ce_n}); end
      end
    end
    n_checks++; if (err_cnt != 0 || done_cnt != 1) begin n_fail++; $display("FAIL held_rd_counts: got err %0d done %0d want 0 1", err_cnt, done_cnt); end
    n_checks++; if (if1.xfer_out !== 8'h11 || if1.mem_addr !== 16'h0042) begin n_fail++; $display("FAIL held_rd_result: got %h/%h want 11/0042", if1.xfer_out, if1.mem_addr); end
  endtask

  task automatic test_reset_abort();
    int oe_cnt = 0, done_at = -1, done_cnt = 0, inc_cnt = 0;
    if3.addr_in = 16'h0ABC; if3.addr_en = 1; if3.rd_n = 0; if3.mem_rdata = 8'h5A;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin if3.rd_n = 1; if3.addr_en = 0; end
      if (if3.mem_oe_n == 1'b0) oe_cnt++;
      if (if3.done == 1'b1) done_at = k;
    end
    n_checks++; if (oe_cnt != 4 || done_at != 6) begin n_fail++; $display("FAIL w3_read: got oe %0d done@%0d want 4 6", oe_cnt, done_at); end
    n_checks++; if (if3.xfer_out !== 8'h5A) begin n_fail++; $display("FAIL w3_read_data: got %h want 5a", if3.xfer_out); end
    if3.addr_in = 16'h0DEF; if3.addr_en = 1; if3.rd_n = 0; if3.post_inc_n = 0; if3.mem_rdata = 8'hC3;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin if3.rd_n = 1; if3.addr_en = 0; if3.post_inc_n = 1; end
      if (if3.done == 1'b1) done_cnt++;
      if (if3.inc_n == 1'b0) inc_cnt++;
      if (k == 3) begin
        n_checks++; if (if3.mem_oe_n !== 1'b0) begin n_fail++; $display("FAIL abort_in_access: got oe_n %b want 0", if3.mem_oe_n); end
        rst3 = 1;
      end
      if (k == 4) begin
        n_checks++; if ({if3.mem_ce_n, if3.mem_oe_n, if3.mem_we_n, if3.busy} !== 4'b1110) begin n_fail++; $display("FAIL abort_strobes: got %b want 1110", {if3.mem_ce_n, if3.mem_oe_n, if3.mem_we_n, if3.busy}); end
        n_checks++; if (if3.xfer_out !== 8'h00 || if3.mem_addr !== 16'h0000) begin n_fail++; $display("FAIL abort_regs: got %h/%h want 00/0000", if3.xfer_out, if3.mem_addr); end
        rst3 = 0;
      end
    end
    n_checks++; if (done_cnt != 0 || inc_cnt != 0) begin n_fail++; $display("FAIL abort_no_pulses: got done %0d inc %0d want 0 0", done_cnt, inc_cnt); end
  endtask

  task automatic test_back_to_back();
    int we_cnt = 0, oe_cnt = 0, overlap = 0, done_cnt = 0, d1 = -1, d2 = -1;
    int addr_bad = 0, wd_bad = 0, we_addr_bad = 0;
    logic [15:0] prev_addr;
    prev_addr = if1.mem_addr;
    if1.addr_in = 16'h0100; if1.xfer_in = 8'h77; if1.wr_n = 0; if1.addr_en = 1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (if1.mem_we_n == 1'b0) we_cnt++;
      if (if1.mem_oe_n == 1'b0) oe_cnt++;
      if (if1.mem_we_n == 1'b0 && if1.mem_oe_n == 1'b0) overlap++;
      if (if1.mem_we_n == 1'b0 && if1.mem_addr !== prev_addr) we_addr_bad++;
      prev_addr = if1.mem_addr;
      if (if1.done == 1'b1) begin
        done_cnt++;
        if (done_cnt == 1) d1 = k; else d2 = k;
      end
      if (k >= 2 && k <= 4 && if1.mem_addr !== 16'h0100) addr_bad++;
      if (k >= 6 && k <= 9 && if1.mem_addr !== 16'h0200) addr_bad++;
      if (k >= 6 && k <= 9 && if1.mem_wdata !== 8'h77) wd_bad++;
      if (k == 1) begin if1.wr_n = 1; if1.addr_en = 0; if1.xfer_in = '0; end
      if (k == 5) begin
        n_checks++; if (if1.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap: got busy %b want 0", if1.busy); end
        if1.rd_n = 0; if1.addr_in = 16'h0200; if1.addr_en = 1; if1.mem_rdata = 8'h99;
      end
      if (k == 6) begin
        n_checks++; if (if1.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_read_accepted: got busy %b want 1", if1.busy); end
        if1.rd_n = 1; if1.addr_en = 0;
      end
    end
    n_checks++; if (we_cnt != 2 || oe_cnt != 2 || overlap != 0) begin n_fail++; $display("FAIL b2b_strobes: got we %0d oe %0d overlap %0d want 2 2 0", we_cnt, oe_cnt, overlap); end
    n_checks++; if (d1 != 4 || d2 != 9) begin n_fail++; $display("FAIL b2b_done: got %0d,%0d want 4,9", d1, d2); end
    n_checks++; if (addr_bad != 0 || wd_bad != 0 || we_addr_bad != 0) begin n_fail++; $display("FAIL b2b_addr_data: got bad addr %0d wdata %0d we/addr %0d want 0", addr_bad, wd_bad, we_addr_bad); end
    n_checks++; if (if1.xfer_out !== 8'h99 || if1.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_result: got %h busy %b want 99 0", if1.xfer_out, if1.busy); end
  endtask

  initial begin
    idle_inputs();
    rst0 = 1; rst1 = 1; rst3 = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst0 = 0; rst1 = 0; rst3 = 0;
    test_reset();
    test_read();
    test_write();
    test_reject();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
